// File: rtl/bcd_digit_scanner_pkg.sv
// Shared constants, types and helpers for the four-digit BCD display scanner.
// The digit_sel encoding is active-low one-hot: bit k low lights digit k.
package bcd_digit_scanner_pkg;

    localparam int          DIGITS    = 4;
    localparam logic [3:0]  DIGIT_OFF = 4'b1111;
    localparam logic [3:0]  BCD_MAX   = 4'd9;

    typedef logic [1:0] slot_t;
    typedef logic [3:0] nibble_t;

    // Why the current slot is (or is not) lit
    typedef enum logic [1:0] {
        DIG_LIT,
        DIG_INVALID,
        DIG_SUPPRESSED,
        DIG_OFF
    } digit_state_t;

    function automatic logic [3:0] digit_sel_for(input slot_t k);
        return ~(4'b0001 << k);
    endfunction

    function automatic logic has_invalid(input logic [15:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > BCD_MAX) r = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_scanner_if.sv
// Control and display bus between the scanner and its parent.
// master = the parent (drives value/control), slave = the scanner.
interface bcd_digit_scanner_if;
    logic        load;
    logic [15:0] value;
    logic        enable;
    logic        blank_lz;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_sel;
    logic        blank;
    logic [1:0]  slot;
    logic        invalid_digit;

    modport master (
        output load, value, enable, blank_lz,
        input  bcd_out, digit_sel, blank, slot, invalid_digit
    );

    modport slave (
        input  load, value, enable, blank_lz,
        output bcd_out, digit_sel, blank, slot, invalid_digit
    );
endinterface

// File: rtl/bcd_digit_scanner_scan_tick_gen.sv
// Refresh prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick on the
// last count. Holding en low freezes the count so a slot resumes where it paused.
module scan_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) count <= '0;
            else               count <= count + 1'b1;
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/bcd_digit_scanner.sv
// Time-multiplexed four-digit BCD scanner: shadow register, slot counter and a
// registered per-slot output stage with leading-zero and invalid-digit blanking.
module bcd_digit_scanner
    import bcd_digit_scanner_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_digit_scanner_if.slave   bus
);
    logic [15:0]  shadow;
    slot_t        slot_q;
    logic         invalid_q;
    logic         tick;

    nibble_t      nibble;
    logic         upper_zero;
    digit_state_t dstate;
    logic [3:0]   sel_d;

    scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (bus.enable),
        .tick  (tick)
    );

    // A load and a tick on the same edge both land, so the new slot sees the new value
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow    <= '0;
            slot_q    <= '0;
            invalid_q <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow    <= bus.value;
                invalid_q <= has_invalid(bus.value);
            end
            if (tick) slot_q <= slot_q + 2'd1;
        end
    end

    always_comb begin
        nibble     = shadow[{slot_q, 2'b00} +: 4];
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if ((i >= int'(slot_q)) && (shadow[4*i +: 4] != 4'd0)) upper_zero = 1'b0;
        end
    end

    // Digit 0 is never zero-suppressed so an all-zero value still shows "0"
    always_comb begin
        dstate = DIG_LIT;
        if (!bus.enable)
            dstate = DIG_OFF;
        else if (nibble > BCD_MAX)
            dstate = DIG_INVALID;
        else if (bus.blank_lz && (slot_q != 2'd0) && upper_zero)
            dstate = DIG_SUPPRESSED;

        sel_d = (dstate == DIG_LIT) ? digit_sel_for(slot_q) : DIGIT_OFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.bcd_out   <= 4'd0;
            bus.digit_sel <= DIGIT_OFF;
            bus.blank     <= 1'b1;
            bus.slot      <= 2'd0;
        end else begin
            bus.bcd_out   <= nibble;
            bus.digit_sel <= sel_d;
            bus.blank     <= (dstate != DIG_LIT);
            bus.slot      <= slot_q;
        end
    end

    assign bus.invalid_digit = invalid_q;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Self-checking bench for bcd_digit_scanner: test-plan vectors, hand-written
// corner sequences and random traffic against a cycle-level reference model.
module tb_bcd_digit_scanner;
    localparam int TICK_DIV = 4;

    logic clk;
    logic reset;

    bcd_digit_scanner_if bus ();

    bcd_digit_scanner #(.TICK_DIV(TICK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks;
    int nFails;

    // Reference model state: total enabled cycles since reset decides the slot
    logic [15:0] mShadow;
    int          mTime;
    logic        mInvalid;

    logic [3:0]  expBcd;
    logic [3:0]  expSel;
    logic        expBlank;
    logic [1:0]  expSlot;
    logic        bcdKnown;

    typedef struct {
        logic [15:0] value;
        logic        blz;
        int          slotWanted;
        logic [3:0]  sel;
        logic [3:0]  bcd;
        logic        blank;
        logic        inv;
    } vec_t;

    vec_t vecs[14];

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic ld, input logic [15:0] val,
                                 input logic en, input logic blz);
        reset        = rst;
        bus.load     = ld;
        bus.value    = val;
        bus.enable   = en;
        bus.blank_lz = blz;
    endtask

    task automatic stepCycle();
        int          k;
        logic [15:0] upper;
        logic [3:0]  n;
        logic        lz;
        logic        lit;
        @(posedge clk);
        if (reset) begin
            expBcd   = 4'd0;
            expSel   = 4'b1111;
            expBlank = 1'b1;
            expSlot  = 2'd0;
            bcdKnown = 1'b1;
            mShadow  = 16'h0000;
            mTime    = 0;
            mInvalid = 1'b0;
        end else begin
            k     = (mTime / TICK_DIV) % 4;
            upper = mShadow >> (4 * k);
            n     = upper[3:0];
            lz    = bus.blank_lz && (k >= 1) && (upper == 16'h0000);
            lit   = bus.enable && (n <= 4'd9) && !lz;
            expBcd   = n;
            expSel   = lit ? ~(4'b0001 << k) : 4'b1111;
            expBlank = !lit;
            expSlot  = 2'(k);
            bcdKnown = lit || !bus.enable;
            if (bus.enable) mTime++;
            if (bus.load) begin
                mShadow  = bus.value;
                mInvalid = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (((bus.value >> (4 * i)) & 16'hF) > 16'd9) mInvalid = 1'b1;
                end
            end
        end
        #1;
        checkOutput("model digit_sel", 16'(bus.digit_sel), 16'(expSel));
        checkOutput("model blank", 16'(bus.blank), 16'(expBlank));
        checkOutput("model slot", 16'(bus.slot), 16'(expSlot));
        checkOutput("model invalid_digit", 16'(bus.invalid_digit), 16'(mInvalid));
        if (bcdKnown) checkOutput("model bcd_out", 16'(bus.bcd_out), 16'(expBcd));
    endtask

    task automatic resetAndLoad(input logic [15:0] val, input logic blz);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, blz);
        stepCycle();
        applyStimulus(1'b0, 1'b1, val, 1'b1, blz);
        stepCycle();
        applyStimulus(1'b0, 1'b0, val, 1'b1, blz);
    endtask

    task automatic runVector(input vec_t v);
        bit found;
        found = 0;
        resetAndLoad(v.value, v.blz);
        for (int c = 0; c < 40 && !found; c++) begin
            stepCycle();
            if (int'(expSlot) == v.slotWanted) found = 1;
        end
        if (!found) begin
            checkOutput("vector slot reached", 16'd0, 16'd1);
        end else begin
            checkOutput("vector digit_sel", 16'(bus.digit_sel), 16'(v.sel));
            checkOutput("vector blank", 16'(bus.blank), 16'(v.blank));
            checkOutput("vector invalid_digit", 16'(bus.invalid_digit), 16'(v.inv));
            if (!v.blank) checkOutput("vector bcd_out", 16'(bus.bcd_out), 16'(v.bcd));
        end
    endtask

    initial begin
        int   cnt;
        bit   found;
        logic [15:0] rv;

        nChecks = 0;
        nFails  = 0;
        mShadow = 16'h0000;
        mTime   = 0;
        mInvalid = 1'b0;

        vecs[0]  = '{16'h1234, 1'b0, 0, 4'b1110, 4'd4, 1'b0, 1'b0};
        vecs[1]  = '{16'h1234, 1'b0, 1, 4'b1101, 4'd3, 1'b0, 1'b0};
        vecs[2]  = '{16'h1234, 1'b0, 2, 4'b1011, 4'd2, 1'b0, 1'b0};
        vecs[3]  = '{16'h1234, 1'b0, 3, 4'b0111, 4'd1, 1'b0, 1'b0};
        vecs[4]  = '{16'h0042, 1'b1, 0, 4'b1110, 4'd2, 1'b0, 1'b0};
        vecs[5]  = '{16'h0042, 1'b1, 1, 4'b1101, 4'd4, 1'b0, 1'b0};
        vecs[6]  = '{16'h0042, 1'b1, 2, 4'b1111, 4'd0, 1'b1, 1'b0};
        vecs[7]  = '{16'h0042, 1'b1, 3, 4'b1111, 4'd0, 1'b1, 1'b0};
        vecs[8]  = '{16'h0000, 1'b1, 0, 4'b1110, 4'd0, 1'b0, 1'b0};
        vecs[9]  = '{16'h0000, 1'b1, 1, 4'b1111, 4'd0, 1'b1, 1'b0};
        vecs[10] = '{16'h0000, 1'b0, 3, 4'b0111, 4'd0, 1'b0, 1'b0};
        vecs[11] = '{16'h12A4, 1'b0, 1, 4'b1111, 4'd0, 1'b1, 1'b1};
        vecs[12] = '{16'h12A4, 1'b0, 2, 4'b1011, 4'd2, 1'b0, 1'b1};
        vecs[13] = '{16'h12A4, 1'b0, 0, 4'b1110, 4'd4, 1'b0, 1'b1};

        // Reset values, then the first slot-0 output right after deassertion
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("reset digit_sel", 16'(bus.digit_sel), 16'h000F);
        checkOutput("reset blank", 16'(bus.blank), 16'd1);
        checkOutput("reset bcd_out", 16'(bus.bcd_out), 16'd0);
        checkOutput("reset invalid_digit", 16'(bus.invalid_digit), 16'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        stepCycle();
        checkOutput("post-reset digit_sel", 16'(bus.digit_sel), 16'h000E);
        checkOutput("post-reset blank", 16'(bus.blank), 16'd0);
        checkOutput("post-reset bcd_out", 16'(bus.bcd_out), 16'd0);

        for (int i = 0; i < 14; i++) runVector(vecs[i]);

        // Invalid flag clears on a following good load
        applyStimulus(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 16'h1234, 1'b1, 1'b0);
        checkOutput("invalid cleared", 16'(bus.invalid_digit), 16'd0);

        // Enable freeze two cycles into slot 2
        resetAndLoad(16'h1234, 1'b0);
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            stepCycle();
            if (expSel == 4'b1011) found = 1;
        end
        checkOutput("freeze reached slot 2", 16'(found), 16'd1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 16'h1234, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            stepCycle();
            checkOutput("frozen digit_sel", 16'(bus.digit_sel), 16'h000F);
            checkOutput("frozen blank", 16'(bus.blank), 16'd1);
            checkOutput("frozen bcd_out", 16'(bus.bcd_out), 16'd2);
        end
        applyStimulus(1'b0, 1'b0, 16'h1234, 1'b1, 1'b0);
        cnt = 0;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            stepCycle();
            if (bus.digit_sel == 4'b1011) cnt++;
            else found = 1;
        end
        checkOutput("slot 2 cycles after re-enable", 16'(cnt), 16'd2);
        checkOutput("slot after resume", 16'(bus.digit_sel), 16'h0007);

        // Reset asserted during slot 3
        resetAndLoad(16'h1234, 1'b0);
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            stepCycle();
            if (expSlot == 2'd3) found = 1;
        end
        checkOutput("reached slot 3", 16'(found), 16'd1);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        stepCycle();
        checkOutput("mid-scan reset digit_sel", 16'(bus.digit_sel), 16'h000F);
        checkOutput("mid-scan reset blank", 16'(bus.blank), 16'd1);
        checkOutput("mid-scan reset slot", 16'(bus.slot), 16'd0);
        checkOutput("mid-scan reset bcd_out", 16'(bus.bcd_out), 16'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        stepCycle();
        checkOutput("restart digit_sel", 16'(bus.digit_sel), 16'h000E);
        checkOutput("restart bcd_out", 16'(bus.bcd_out), 16'd0);

        // Load on the same edge as the slot 1 -> 2 tick
        resetAndLoad(16'h1234, 1'b0);
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            stepCycle();
            if (mTime % (4 * TICK_DIV) == 2 * TICK_DIV - 1) found = 1;
        end
        checkOutput("reached end of slot 1", 16'(found), 16'd1);
        applyStimulus(1'b0, 1'b1, 16'h5678, 1'b1, 1'b0);
        stepCycle();
        checkOutput("pre-tick digit_sel", 16'(bus.digit_sel), 16'h000D);
        checkOutput("pre-tick bcd_out", 16'(bus.bcd_out), 16'd3);
        applyStimulus(1'b0, 1'b0, 16'h5678, 1'b1, 1'b0);
        stepCycle();
        checkOutput("coincident digit_sel", 16'(bus.digit_sel), 16'h000B);
        checkOutput("coincident bcd_out", 16'(bus.bcd_out), 16'd6);

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            rv = 16'($urandom);
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < 4; i++) rv[4*i +: 4] = 4'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 9));
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 11) == 0, rv,
                          $urandom_range(0, 7) != 0,
                          (c % 150) < 75 ? 1'b1 : ($urandom_range(0, 15) == 0));
            stepCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
